regfile_mp_scoreboard: RTL and testbench
========================================

// Module: regfile_mp_scoreboard
// PURPOSE
//   Parametrised integer register file for the pipelined core: 2 async read ports, 2 sync write
//   ports (wp0 = ALU writeback, wp1 = late/load writeback), optional write-through bypass, and
//   a per-register busy scoreboard set at issue and cleared at writeback. Sits between decode
//   (reads, issue marking) and writeback. Reset sweeps all registers to zero over NREGS cycles.
// PARAMETERS
//   XLEN      32  data width in bits
//   NREGS     32  number of architectural registers (power of 2, >= 4)
//   AW         5  index width, = $clog2(NREGS)
//   ZERO_REG   1  1: reg 0 hardwired to 0 (writes/issues to 0 ignored); 0: reg 0 is ordinary
//   BYPASS     1  1: same-cycle write data forwarded to read ports; 0: reads see array only
// PORTS
//   clk        in   1     clock, all state updates on posedge
//   reset      in   1     synchronous, active-high
//   ready      out  1     1 = init sweep done, block accepts writes/issues
//   rs1, rs2   in   AW    read indices
//   rd_data1   out  XLEN  read data port 1 (combinational)
//   rd_data2   out  XLEN  read data port 2 (combinational)
//   rd_busy1   out  1     scoreboard busy for rs1 (combinational)
//   rd_busy2   out  1     scoreboard busy for rs2 (combinational)
//   we0, ws0   in   1,AW  write port 0 enable / index
//   wd0        in   XLEN  write port 0 data
//   we1, ws1   in   1,AW  write port 1 enable / index
//   wd1        in   XLEN  write port 1 data
//   iss_en     in   1     issue: mark iss_rd busy
//   iss_rd     in   AW    destination index of issued instruction
// BEHAVIOUR
//   States: INIT, READY. reset=1 in any state -> INIT, sweep counter = 0, busy[] = 0, ready = 0.
//   INIT: each cycle writes 0 to reg[counter], counter++; after reg NREGS-1 is written -> READY
//     next cycle. reset is held synchronous; counter stays 0 while reset=1. Sweep takes exactly
//     NREGS cycles after reset deasserts; ready rises on cycle NREGS+1 after deassert edge.
//   During INIT: we0/we1/iss_en ignored; rd_data* = 0, rd_busy* = 0.
//   Reset mid-sweep or mid-operation: sweep restarts from 0; pending busy bits discarded.
//   Writes (READY): posedge stores wdN to reg[wsN] when weN. Both ports same index: wp1 wins.
//     Index 0 with ZERO_REG=1: write dropped, reg 0 reads 0 always.
//   Read: rd_dataK = reg[rsK]; BYPASS=1 and weN && wsN==rsK (and not dropped) -> wdN
//     (wp1 over wp0 if both match). BYPASS=0: new value visible the cycle after the edge.
//   Scoreboard: iss_en sets busy[iss_rd]; weN clears busy[wsN]. iss_en and a write to the same
//     index in one cycle -> busy stays 1 (new producer). ZERO_REG=1: busy[0] never set.
//   rd_busyK = busy[rsK]; BYPASS=1 and a valid write to rsK this cycle -> 0 (data forwarded),
//     unless iss_en targets rsK in the same cycle (array busy state still follows the rule above).
//   No arithmetic on data; indices compared on full AW bits; no wrap except sweep counter.
//   Outputs after reset: ready=0, rd_data*=0, rd_busy*=0 until READY.
// TESTING
//   1 reset 1 cycle, release -> ready=0 for 32 cycles, 1 on 33rd; any rs reads 0 throughout.
//   2 READY: we0 ws0=5 wd0=0xDEAD_BEEF, rs1=5 same cycle -> rd_data1=0xDEADBEEF (BYPASS=1);
//     BYPASS=0 build -> old value 0, then 0xDEADBEEF next cycle.
//   3 we0 ws0=7 wd0=0x11, we1 ws1=7 wd1=0x22 same cycle -> reg7 = 0x22, bypass shows 0x22.
//   4 iss_en iss_rd=3 -> rd_busy(rs=3)=1 next cycle; we1 ws1=3 -> busy 0 after edge; iss+write
//     to 3 same cycle -> busy stays 1. iss_rd=0 / ws=0 wd=0xFF -> busy 0, reads 0.
//   5 reset asserted at sweep count 10, then in READY with busy[4]=1 and reg4=0x55 -> sweep
//     restarts, ready=0 for 32 cycles, afterwards reg4=0, busy[4]=0; writes in INIT dropped.

Source files
------------

// File: rtl/regfile_mp_scoreboard_if.sv
// regfile_mp_scoreboard_if: read/write/issue bus of the register file; master = core pipeline, slave = register file
interface regfile_mp_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            ready;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rd_data1;
  logic [XLEN-1:0] rd_data2;
  logic            rd_busy1;
  logic            rd_busy2;
  logic            we0;
  logic [AW-1:0]   ws0;
  logic [XLEN-1:0] wd0;
  logic            we1;
  logic [AW-1:0]   ws1;
  logic [XLEN-1:0] wd1;
  logic            iss_en;
  logic [AW-1:0]   iss_rd;
  modport master (
    input  ready, rd_data1, rd_data2, rd_busy1, rd_busy2,
    output rs1, rs2, we0, ws0, wd0, we1, ws1, wd1, iss_en, iss_rd
  );
  modport slave (
    output ready, rd_data1, rd_data2, rd_busy1, rd_busy2,
    input  rs1, rs2, we0, ws0, wd0, we1, ws1, wd1, iss_en, iss_rd
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: 2R/2W register file with write-through bypass, busy scoreboard and zeroing sweep after reset (ports: clk, reset, bus slave)
module regfile_mp_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic reset,
  regfile_mp_scoreboard_if.slave bus
);
  typedef enum logic {INIT, READY} state_t;
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  localparam bit ZR = ZERO_REG != 0;
  localparam bit BP = BYPASS != 0;
  state_t state_q;
  logic [AW-1:0] cnt_q;
  logic ready_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic v0, v1, vi, f1, f2;
  assign v0 = ready_q && bus.we0 && !(ZR && bus.ws0 == '0);
  assign v1 = ready_q && bus.we1 && !(ZR && bus.ws1 == '0);
  assign vi = ready_q && bus.iss_en && !(ZR && bus.iss_rd == '0);
  assign f1 = BP && ((v1 && bus.ws1 == bus.rs1) || (v0 && bus.ws0 == bus.rs1));
  assign f2 = BP && ((v1 && bus.ws1 == bus.rs2) || (v0 && bus.ws0 == bus.rs2));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_q <= READY;
        ready_q <= 1'b1;
      end
    end
  end
  // issue is applied after writeback clears so a same-cycle new producer keeps the register busy
  always_comb begin
    busy_d = busy_q;
    if (v0) busy_d[bus.ws0] = 1'b0;
    if (v1) busy_d[bus.ws1] = 1'b0;
    if (vi) busy_d[bus.iss_rd] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else if (!ready_q) begin
      regs_q[cnt_q] <= '0;
    end else begin
      busy_q <= busy_d;
      if (v0) regs_q[bus.ws0] <= bus.wd0;
      if (v1) regs_q[bus.ws1] <= bus.wd1;
    end
  end
  assign bus.ready    = ready_q;
  assign bus.rd_data1 = !ready_q ? '0 :
                        (BP && v1 && bus.ws1 == bus.rs1) ? bus.wd1 :
                        (BP && v0 && bus.ws0 == bus.rs1) ? bus.wd0 : regs_q[bus.rs1];
  assign bus.rd_data2 = !ready_q ? '0 :
                        (BP && v1 && bus.ws1 == bus.rs2) ? bus.wd1 :
                        (BP && v0 && bus.ws0 == bus.rs2) ? bus.wd0 : regs_q[bus.rs2];
  // forwarded data hides busy unless the same cycle issues a new producer to that register
  assign bus.rd_busy1 = ready_q && busy_q[bus.rs1] && !(f1 && !(vi && bus.iss_rd == bus.rs1));
  assign bus.rd_busy2 = ready_q && busy_q[bus.rs2] && !(f2 && !(vi && bus.iss_rd == bus.rs2));
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb_regfile_mp_scoreboard: directed self-checking bench for regfile_mp_scoreboard
module tb_regfile_mp_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  regfile_mp_scoreboard_if #(.XLEN(32), .AW(5)) bus ();
  regfile_mp_scoreboard #(.XLEN(32), .NREGS(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.we0 = 0; bus.we1 = 0; bus.iss_en = 0;
  endtask
  task automatic test_reset;
    idle();
    bus.rs1 = 5'd4; bus.rs2 = 5'd0; bus.ws0 = 0; bus.ws1 = 0; bus.wd0 = 0; bus.wd1 = 0; bus.iss_rd = 0;
    reset = 1;
    step(); step();
    reset = 0;
    bus.we0 = 1; bus.ws0 = 5'd4; bus.wd0 = 32'h99;
    bus.iss_en = 1; bus.iss_rd = 5'd4;
    for (int i = 1; i <= 32; i++) begin
      #1;
      tests++;
      if (bus.ready !== 1'b0 || bus.rd_data1 !== 32'h0 || bus.rd_busy1 !== 1'b0) begin
        fails++;
        $display("FAIL init_cycle%0d ready=%b data=%h busy=%b want 0,0,0", i, bus.ready, bus.rd_data1, bus.rd_busy1);
      end
      step();
    end
    idle();
    #1;
    tests++;
    if (bus.ready !== 1'b1) begin fails++; $display("FAIL ready_rise got %b want 1", bus.ready); end
    tests++;
    if (bus.rd_data1 !== 32'h0 || bus.rd_busy1 !== 1'b0) begin
      fails++;
      $display("FAIL init_writes_dropped data=%h busy=%b want 0,0", bus.rd_data1, bus.rd_busy1);
    end
  endtask
  task automatic test_bypass;
    step();
    bus.we0 = 1; bus.ws0 = 5'd5; bus.wd0 = 32'hDEAD_BEEF; bus.rs1 = 5'd5; bus.rs2 = 5'd6;
    #1;
    tests++;
    if (bus.rd_data1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bypass_wp0 got %h want deadbeef", bus.rd_data1); end
    tests++;
    if (bus.rd_data2 !== 32'h0) begin fails++; $display("FAIL bypass_other got %h want 0", bus.rd_data2); end
    step();
    idle();
    #1;
    tests++;
    if (bus.rd_data1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL stored_wp0 got %h want deadbeef", bus.rd_data1); end
  endtask
  task automatic test_dual_write;
    bus.we0 = 1; bus.ws0 = 5'd7; bus.wd0 = 32'h11;
    bus.we1 = 1; bus.ws1 = 5'd7; bus.wd1 = 32'h22;
    bus.rs1 = 5'd7; bus.rs2 = 5'd7;
    #1;
    tests++;
    if (bus.rd_data1 !== 32'h22 || bus.rd_data2 !== 32'h22) begin
      fails++;
      $display("FAIL dual_bypass got %h/%h want 22", bus.rd_data1, bus.rd_data2);
    end
    step();
    bus.ws0 = 5'd8; bus.wd0 = 32'hA; bus.ws1 = 5'd9; bus.wd1 = 32'hB;
    step();
    idle();
    bus.rs2 = 5'd8;
    #1;
    tests++;
    if (bus.rd_data1 !== 32'h22) begin fails++; $display("FAIL dual_same_idx got %h want 22", bus.rd_data1); end
    tests++;
    if (bus.rd_data2 !== 32'hA) begin fails++; $display("FAIL dual_wp0 got %h want a", bus.rd_data2); end
    bus.rs1 = 5'd9;
    #1;
    tests++;
    if (bus.rd_data1 !== 32'hB) begin fails++; $display("FAIL dual_wp1 got %h want b", bus.rd_data1); end
  endtask
  task automatic test_scoreboard;
    step();
    bus.iss_en = 1; bus.iss_rd = 5'd3; bus.rs1 = 5'd3; bus.rs2 = 5'd3;
    #1;
    tests++;
    if (bus.rd_busy1 !== 1'b0) begin fails++; $display("FAIL busy_before_edge got %b want 0", bus.rd_busy1); end
    step();
    idle();
    #1;
    tests++;
    if (bus.rd_busy1 !== 1'b1 || bus.rd_busy2 !== 1'b1) begin
      fails++;
      $display("FAIL busy_set got %b/%b want 1", bus.rd_busy1, bus.rd_busy2);
    end
    bus.we1 = 1; bus.ws1 = 5'd3; bus.wd1 = 32'h33;
    #1;
    tests++;
    if (bus.rd_busy1 !== 1'b0 || bus.rd_data1 !== 32'h33) begin
      fails++;
      $display("FAIL busy_fwd busy=%b data=%h want 0,33", bus.rd_busy1, bus.rd_data1);
    end
    step();
    idle();
    #1;
    tests++;
    if (bus.rd_busy1 !== 1'b0) begin fails++; $display("FAIL busy_clear got %b want 0", bus.rd_busy1); end
    bus.iss_en = 1; bus.iss_rd = 5'd3; bus.we0 = 1; bus.ws0 = 5'd3; bus.wd0 = 32'h44;
    step();
    idle();
    #1;
    tests++;
    if (bus.rd_busy1 !== 1'b1 || bus.rd_data1 !== 32'h44) begin
      fails++;
      $display("FAIL iss_and_write busy=%b data=%h want 1,44", bus.rd_busy1, bus.rd_data1);
    end
    bus.iss_en = 1; bus.iss_rd = 5'd3; bus.we0 = 1; bus.ws0 = 5'd3; bus.wd0 = 32'h45;
    #1;
    tests++;
    if (bus.rd_busy1 !== 1'b1) begin fails++; $display("FAIL iss_masks_fwd got %b want 1", bus.rd_busy1); end
    bus.iss_en = 0;
    step();
    step();
    idle();
    bus.iss_en = 1; bus.iss_rd = 5'd0; bus.we1 = 1; bus.ws1 = 5'd0; bus.wd1 = 32'hFF; bus.rs1 = 5'd0;
    #1;
    tests++;
    if (bus.rd_data1 !== 32'h0 || bus.rd_busy1 !== 1'b0) begin
      fails++;
      $display("FAIL zero_bypass data=%h busy=%b want 0,0", bus.rd_data1, bus.rd_busy1);
    end
    step();
    idle();
    #1;
    tests++;
    if (bus.rd_data1 !== 32'h0 || bus.rd_busy1 !== 1'b0) begin
      fails++;
      $display("FAIL zero_reg data=%h busy=%b want 0,0", bus.rd_data1, bus.rd_busy1);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] vals [4] = '{32'h1, 32'hCAFE_0000, 32'h0F0F_0F0F, 32'hFFFF_FFFF};
    bus.rs1 = 5'd31; bus.rs2 = 5'd31;
    for (int i = 0; i < 4; i++) begin
      bus.we0 = (i % 2) == 0; bus.we1 = (i % 2) == 1;
      bus.ws0 = 5'd31; bus.ws1 = 5'd31; bus.wd0 = vals[i]; bus.wd1 = vals[i];
      #1;
      tests++;
      if (bus.rd_data1 !== vals[i]) begin fails++; $display("FAIL b2b_%0d got %h want %h", i, bus.rd_data1, vals[i]); end
      step();
    end
    idle();
    #1;
    tests++;
    if (bus.rd_data2 !== 32'hFFFF_FFFF) begin fails++; $display("FAIL b2b_final got %h want ffffffff", bus.rd_data2); end
  endtask
  task automatic test_mid_reset;
    bus.we0 = 1; bus.ws0 = 5'd4; bus.wd0 = 32'h55; bus.iss_en = 1; bus.iss_rd = 5'd4;
    bus.rs1 = 5'd4; bus.rs2 = 5'd4;
    step();
    idle();
    #1;
    tests++;
    if (bus.rd_data1 !== 32'h55 || bus.rd_busy1 !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset data=%h busy=%b want 55,1", bus.rd_data1, bus.rd_busy1);
    end
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 10; i++) step();
    reset = 1;
    step();
    reset = 0;
    bus.we0 = 1; bus.ws0 = 5'd4; bus.wd0 = 32'h77; bus.iss_en = 1; bus.iss_rd = 5'd4;
    for (int i = 1; i <= 32; i++) begin
      #1;
      tests++;
      if (bus.ready !== 1'b0 || bus.rd_data1 !== 32'h0 || bus.rd_busy1 !== 1'b0) begin
        fails++;
        $display("FAIL resweep_cycle%0d ready=%b data=%h busy=%b want 0,0,0", i, bus.ready, bus.rd_data1, bus.rd_busy1);
      end
      step();
    end
    idle();
    #1;
    tests++;
    if (bus.ready !== 1'b1) begin fails++; $display("FAIL resweep_ready got %b want 1", bus.ready); end
    tests++;
    if (bus.rd_data2 !== 32'h0 || bus.rd_busy2 !== 1'b0) begin
      fails++;
      $display("FAIL resweep_reg4 data=%h busy=%b want 0,0", bus.rd_data2, bus.rd_busy2);
    end
    bus.rs1 = 5'd7;
    #1;
    tests++;
    if (bus.rd_data1 !== 32'h0) begin fails++; $display("FAIL resweep_reg7 got %h want 0", bus.rd_data1); end
  endtask
  initial begin
    test_reset();
    test_bypass();
    test_dual_write();
    test_scoreboard();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
